bitwise_logic_unit: RTL

Parametrised, multi-cycle bitwise logic unit for the KGP-RISC execute stage. It generalises a fixed 32-bit AND into an eight-operation logic engine of configurable width. Each operand pair is processed SLICE bits per cycle under a valid/ready handshake, so wide datapaths can trade latency for area. A zero flag is produced alongside the result for the branch/flag logic.

---
 rtl/bitwise_logic_unit_if.sv | 25 ++
 rtl/bitwise_logic_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit_if.sv
// Valid/ready request/response bundle for the bitwise logic unit.
// The requester takes the master side and the unit takes the slave side.
interface bitwise_logic_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic engine: eight operations, SLICE bits per cycle, LSB slice first,
// with a zero flag accumulated across slices. IDLE -> RUN (N cycles) -> DONE handshake.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bitwise_logic_unit_if.slave  bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("bitwise_logic_unit: WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_XNOR  = 3'b101,
        OP_ANDN  = 3'b110,
        OP_PASSA = 3'b111
    } op_t;

    state_t           state;
    op_t              op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    k;
    logic             zero_acc;
    logic             out_valid_reg;
    logic             in_ready;
    logic             accept;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] slice;

    // in_ready must drop the moment rst rises and come back as soon as it falls,
    // so it is decoded from the state rather than held in its own flop.
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_ready && bus.in_valid;

    // NOTE: operand registers carry no reset; they are only read after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            op_reg <= op_t'(bus.op);
        end
    end

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        a_sl  = a_reg[int'(k)*SLICE +: SLICE];
        b_sl  = b_reg[int'(k)*SLICE +: SLICE];
        slice = '0;
        case (op_reg)
            OP_AND:   slice = a_sl & b_sl;
            OP_OR:    slice = a_sl | b_sl;
            OP_XOR:   slice = a_sl ^ b_sl;
            OP_NOR:   slice = ~(a_sl | b_sl);
            OP_NAND:  slice = ~(a_sl & b_sl);
            OP_XNOR:  slice = ~(a_sl ^ b_sl);
            OP_ANDN:  slice = a_sl & ~b_sl;
            OP_PASSA: slice = a_sl;
            default:  slice = a_sl;
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            res_reg       <= '0;
            zero_acc      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        k        <= '0;
                        zero_acc <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_reg[int'(k)*SLICE +: SLICE] <= slice;
                    zero_acc <= zero_acc & ~|slice;
                    if (k == K_LAST) begin
                        k             <= '0;
                        state         <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are gated so result/zero read as zero whenever no result is being offered.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = out_valid_reg ? res_reg : '0;
    assign bus.zero      = out_valid_reg & zero_acc;
endmodule
